// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and valid/ready byte output
//
// Purpose:
//   Recovers 8N1 frames (start, 8 data LSB-first, stop) from an asynchronous
//   serial line. Bits are sampled in the middle of each bit period. False
//   starts are dropped, bad stop bits raise a framing-error pulse, and a byte
//   that lands on top of an unaccepted one raises an overrun pulse.
//
// Ports:
//   i_clk          single clock, rising edge
//   i_sync_reset   synchronous reset, active-high
//   i_rx           serial line, asynchronous, idle high
//   o_rx_data      received byte, meaningful while o_rx_valid is high
//   o_rx_valid     byte available, held until accepted
//   i_rx_ready     consumer accepts when o_rx_valid and i_rx_ready are both high
//   o_frame_error  one-cycle pulse when the stop bit is sampled low
//   o_overrun      one-cycle pulse when a byte completes over an unaccepted one
//   o_busy         high whenever the receiver is not idle

module uart_receiver #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_clk,
  input  logic       i_sync_reset,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_frame_error,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [15:0] LP_BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_error;
  logic        r_overrun;

  logic        w_rx_s;
  logic        w_half_end;
  logic        w_bit_end;
  logic        w_busy;
  logic        w_shift_en;
  logic        w_load;
  logic        w_ferr;

  assign w_rx_s     = r_sync2;
  assign w_half_end = (r_cnt == LP_HALF_END);
  assign w_bit_end  = (r_cnt == LP_BIT_END);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_next_state = S_START;
      end
      S_START: begin
        // Line back high at mid start bit means a glitch, not a frame.
        if (w_half_end) w_next_state = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_idx == 3'd7)) w_next_state = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (w_bit_end) w_next_state = w_rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      S_DATA: w_shift_en = w_bit_end;
      S_STOP: begin
        w_load = w_bit_end && w_rx_s;
        w_ferr = w_bit_end && !w_rx_s;
      end
      default: ;
    endcase
  end

  // Datapath: synchronizer, bit timer, shift register, output handshake
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_cnt         <= 16'd0;
      r_idx         <= 3'd0;
      r_shift       <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;

      if (w_next_state != r_state) begin
        r_cnt <= 16'd0;
        r_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_cnt <= 16'd0;
        r_idx <= r_idx + 3'd1;
      end else if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_shift_en) r_shift[r_idx] <= w_rx_s;

      r_frame_error <= w_ferr;
      r_overrun     <= 1'b0;

      if (w_load) begin
        // A same-cycle accept frees the slot, so only an unaccepted byte overruns.
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
        r_overrun  <= r_rx_valid && !i_rx_ready;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_frame_error = r_frame_error;
  assign o_overrun     = r_overrun;
  assign o_busy        = w_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int C    = 4;
  localparam int HALF = C / 2;

  logic       clk        = 1'b0;
  logic       sync_reset = 1'b1;
  logic       rx         = 1'b1;
  logic       rx_ready   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .i_clk         (clk),
    .i_sync_reset  (sync_reset),
    .i_rx          (rx),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .o_frame_error (frame_error),
    .o_overrun     (overrun),
    .o_busy        (busy)
  );

  // Frame-level reference: every frame the bench sends is logged with the
  // edge at which its stop bit is judged and the edge at which busy rises.
  typedef struct {
    int         bstart;
    int         done;
    logic [7:0] data;
    logic       ok;
  } frame_t;

  frame_t     frames [0:255];
  int         n_frames = 0;

  int         cyc     = 0;
  int         m_idx   = 0;
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;
  logic       m_busy  = 1'b0;

  always @(posedge clk) begin : model
    int         e;
    int         idx;
    logic       v;
    logic       fe;
    logic       ov;
    logic       b;
    logic [7:0] d;
    e   = cyc + 1;
    idx = m_idx;
    if (sync_reset) begin
      v = 1'b0; d = 8'h00; fe = 1'b0; ov = 1'b0;
      idx = n_frames;
    end else begin
      v = m_valid; d = m_data; fe = 1'b0; ov = 1'b0;
      if (idx < n_frames && frames[idx].done == e) begin
        if (frames[idx].ok) begin
          ov = m_valid && !rx_ready;
          d  = frames[idx].data;
          v  = 1'b1;
        end else begin
          fe = 1'b1;
          if (m_valid && rx_ready) v = 1'b0;
        end
        idx++;
      end else if (m_valid && rx_ready) begin
        v = 1'b0;
      end
    end
    b = (idx < n_frames) && (e >= frames[idx].bstart);
    cyc     <= e;
    m_idx   <= idx;
    m_valid <= v;
    m_data  <= d;
    m_fe    <= fe;
    m_ov    <= ov;
    m_busy  <= b;
  end

  int         n_tests   = 0;
  int         n_fail    = 0;
  bit         chk_en    = 0;
  bit         busy_chk  = 1;
  bit         rand_ready = 0;
  int         cnt_fe    = 0;
  int         cnt_ov    = 0;
  int         cnt_busy  = 0;
  int         last_rise = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] log_d [0:255];
  int         n_log     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_cycle();
    check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
    check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
    check("frame_error", {31'd0, frame_error}, {31'd0, m_fe});
    check("overrun", {31'd0, overrun}, {31'd0, m_ov});
    if (busy_chk) check("busy", {31'd0, busy}, {31'd0, m_busy});
    if (frame_error) cnt_fe++;
    if (overrun) cnt_ov++;
    if (busy) cnt_busy++;
    if (rx_valid && !prev_valid) begin
      last_rise = cyc;
      if (n_log < 256) begin
        log_d[n_log] = rx_data;
        n_log++;
      end
    end
    prev_valid = rx_valid;
  endtask

  // One clock: compare on the falling edge, then drive just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_cycle();
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  // Drives one frame; the line is left at the stop-bit level. abort_bit >= 0
  // pulses reset in the middle of that data bit instead of finishing.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int abort_bit);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    frames[n_frames].bstart = cyc + 3;
    frames[n_frames].done   = cyc + 3 + HALF + 9 * C;
    frames[n_frames].data   = d;
    frames[n_frames].ok     = stop_b;
    n_frames++;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        repeat (HALF) tick();
        rx = 1'b1;
        sync_reset = 1'b1;
        repeat (2) tick();
        sync_reset = 1'b0;
        return;
      end
      repeat (C) tick();
    end
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    int e0;
    int fe0;
    int ov0;
    int b0;
    int log0;

    repeat (3) tick();
    sync_reset = 1'b0;
    chk_en = 1;

    // Idle line after reset
    b0 = cnt_busy;
    repeat (100) tick();
    check("idle_busy_cycles", cnt_busy - b0, 0);
    check("idle_flags", cnt_fe + cnt_ov, 0);
    check("idle_valid", {31'd0, rx_valid}, 0);

    // Single byte, latency and hold
    e0 = cyc + 1;
    send_frame(8'hA5, 1'b1, -1);
    repeat (5) tick();
    check("a5_latency", last_rise - e0, 40);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_valid_held", {31'd0, rx_valid}, 1);
    accept();
    check("a5_valid_cleared", {31'd0, rx_valid}, 0);

    // Back-to-back frames with the consumer always ready
    log0 = n_log; fe0 = cnt_fe; ov0 = cnt_ov;
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    repeat (8) tick();
    rx_ready = 1'b0;
    check("b2b_count", n_log - log0, 3);
    check("b2b_byte0", {24'd0, log_d[log0]}, 32'h00);
    check("b2b_byte1", {24'd0, log_d[log0 + 1]}, 32'hFF);
    check("b2b_byte2", {24'd0, log_d[log0 + 2]}, 32'h3C);
    check("b2b_no_flags", (cnt_fe - fe0) + (cnt_ov - ov0), 0);

    // Framing error followed by a held-low line
    busy_chk = 0;
    fe0 = cnt_fe;
    send_frame(8'h55, 1'b0, -1);
    repeat (20) tick();
    check("ferr_wait_busy", {31'd0, busy}, 1);
    check("ferr_valid", {31'd0, rx_valid}, 0);
    rx = 1'b1;
    repeat (6) tick();
    check("ferr_idle_again", {31'd0, busy}, 0);
    busy_chk = 1;
    check("ferr_pulses", cnt_fe - fe0, 1);
    log0 = n_log;
    send_frame(8'h12, 1'b1, -1);
    repeat (3) tick();
    check("ferr_next_count", n_log - log0, 1);
    check("ferr_next_data", {24'd0, log_d[log0]}, 32'h12);
    accept();

    // Overrun
    ov0 = cnt_ov;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    repeat (4) tick();
    check("ovr_pulses", cnt_ov - ov0, 1);
    check("ovr_data", {24'd0, rx_data}, 32'h22);
    check("ovr_valid", {31'd0, rx_valid}, 1);
    accept();

    // One-cycle glitch
    busy_chk = 0;
    b0 = cnt_busy; fe0 = cnt_fe; ov0 = cnt_ov;
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (10) tick();
    busy_chk = 1;
    check("glitch_busy_bounded", {31'd0, (cnt_busy - b0 > 0) && (cnt_busy - b0 <= HALF)}, 1);
    check("glitch_no_flags", (cnt_fe - fe0) + (cnt_ov - ov0), 0);

    // Reset during data bit 4, with a byte already pending
    send_frame(8'h5A, 1'b1, -1);
    repeat (3) tick();
    check("rst_pre_valid", {31'd0, rx_valid}, 1);
    send_frame(8'h81, 1'b1, 4);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    log0 = n_log;
    send_frame(8'h81, 1'b1, -1);
    repeat (3) tick();
    check("rst_next_data", {24'd0, log_d[log0]}, 32'h81);
    accept();

    // Random bytes, gaps and consumer behaviour
    rand_ready = 1;
    for (int k = 0; k < 40; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, -1);
      repeat ($urandom_range(0, 6)) tick();
    end
    rand_ready = 0;
    rx_ready = 1'b1;
    repeat (5) tick();
    rx_ready = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
